// File: rtl/gc_response_rx.sv
// -----------------------------------------------------------------------------
// gc_response_rx
// Receives the 64-bit response that a game controller sends back after the poll
// generator has issued its command and released the bus. Each bit begins with a
// falling edge on the open-drain data line. The bit value is the line level
// SAMPLE_DLY cycles after that edge (short low = 1, long low = 0). The block also
// drives the poll generator's ready input: it holds ready high for READY_HOLD
// cycles, and the falling edge of ready starts the next poll.
//
// Ports
//   i_clk         system clock (60 MHz)
//   i_reset_n     asynchronous, active-low reset
//   i_gc_enable   from poll gen: 1 = line released (listen), 0 = poll gen driving
//   i_gc_data     raw controller data line, idles high, asynchronous to i_clk
//   o_ready       to poll gen ready: high holds it, a falling edge starts a poll
//   o_resp_data   last good response; first received bit is in [RESP_BITS-1]
//   o_resp_valid  one-cycle pulse when o_resp_data updates
//   o_resp_error  one-cycle pulse on timeout or abort
// -----------------------------------------------------------------------------
module gc_response_rx #(
    parameter int SAMPLE_DLY = 120,
    parameter int FIRST_TMO  = 600,
    parameter int BIT_TMO    = 300,
    parameter int READY_HOLD = 60000,
    parameter int RESP_BITS  = 64
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_gc_enable,
    input  logic                 i_gc_data,
    output logic                 o_ready,
    output logic [RESP_BITS-1:0] o_resp_data,
    output logic                 o_resp_valid,
    output logic                 o_resp_error
);

    localparam int MAX_TMO = (FIRST_TMO > BIT_TMO) ? FIRST_TMO : BIT_TMO;
    localparam int HOLD_W  = $clog2(READY_HOLD + 1);
    localparam int TMO_W   = $clog2(MAX_TMO + 1);
    localparam int DLY_W   = $clog2(SAMPLE_DLY + 1);
    localparam int BIT_W   = $clog2(RESP_BITS + 1);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(READY_HOLD - 1);
    localparam logic [TMO_W-1:0]  FIRST_LIM = TMO_W'(FIRST_TMO);
    localparam logic [TMO_W-1:0]  BIT_LIM   = TMO_W'(BIT_TMO);
    localparam logic [DLY_W-1:0]  DLY_LAST  = DLY_W'(SAMPLE_DLY - 1);
    localparam logic [BIT_W-1:0]  BITS_ALL  = BIT_W'(RESP_BITS);

    typedef enum logic [2:0] {
        S_HOLD,
        S_ARM,
        S_WAIT_EDGE,
        S_SAMPLE,
        S_WAIT_HIGH,
        S_COMMIT,
        S_ERROR
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic                 r_sd_meta;
    logic                 r_sd;
    logic                 r_sd_q;
    logic                 r_en;
    logic                 r_en_q;
    logic [HOLD_W-1:0]    r_hold_cnt;
    logic [TMO_W-1:0]     r_tmo;
    logic [DLY_W-1:0]     r_dly;
    logic [BIT_W-1:0]     r_bitcnt;
    logic [RESP_BITS-1:0] r_shift;
    logic [RESP_BITS-1:0] r_resp_data;

    logic                 w_fall;
    logic                 w_en_rise;
    logic [TMO_W-1:0]     w_tmo_inc;
    logic [TMO_W-1:0]     w_tmo_lim;
    logic                 w_tmo_hit;
    logic                 w_sample_now;
    logic                 w_commit;

    // Line synchronizer and enable register. The synchronizer resets to the idle-high
    // level so that leaving reset cannot look like a falling edge.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sd_meta <= 1'b1;
            r_sd      <= 1'b1;
            r_sd_q    <= 1'b1;
            r_en      <= 1'b0;
            r_en_q    <= 1'b0;
        end else begin
            r_sd_meta <= i_gc_data;
            r_sd      <= r_sd_meta;
            r_sd_q    <= r_sd;
            r_en      <= i_gc_enable;
            r_en_q    <= r_en;
        end
    end

    assign w_fall    = r_sd_q & ~r_sd;
    assign w_en_rise = r_en & ~r_en_q;

    // The timeout count runs from the most recent falling edge. Before the first
    // bit, it runs from the release of the bus instead, and then the longer limit applies.
    assign w_tmo_inc    = r_tmo + 1'b1;
    assign w_tmo_lim    = (r_bitcnt == '0) ? FIRST_LIM : BIT_LIM;
    assign w_tmo_hit    = (w_tmo_inc >= w_tmo_lim);
    assign w_sample_now = (r_state == S_SAMPLE) && r_en && (r_dly == DLY_LAST);
    assign w_commit     = (r_state == S_WAIT_HIGH) && r_en && r_sd && (r_bitcnt == BITS_ALL);

    // State register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_HOLD;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic. Losing the enable mid-frame aborts the frame. When an edge
    // and a timeout occur in the same cycle, the edge takes priority. Falls seen
    // during SAMPLE are ignored, so a glitch cannot move the sample point.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_HOLD: begin
                if (r_hold_cnt == HOLD_LAST) begin
                    w_state_next = S_ARM;
                end
            end
            S_ARM: begin
                if (w_en_rise) begin
                    w_state_next = S_WAIT_EDGE;
                end
            end
            S_WAIT_EDGE: begin
                if (!r_en) begin
                    w_state_next = S_ERROR;
                end else if (w_fall) begin
                    w_state_next = S_SAMPLE;
                end else if (w_tmo_hit) begin
                    w_state_next = S_ERROR;
                end
            end
            S_SAMPLE: begin
                if (!r_en) begin
                    w_state_next = S_ERROR;
                end else if (r_dly == DLY_LAST) begin
                    w_state_next = S_WAIT_HIGH;
                end
            end
            S_WAIT_HIGH: begin
                if (!r_en) begin
                    w_state_next = S_ERROR;
                end else if (r_sd) begin
                    w_state_next = (r_bitcnt == BITS_ALL) ? S_COMMIT : S_WAIT_EDGE;
                end else if (w_tmo_hit) begin
                    w_state_next = S_ERROR;
                end
            end
            S_COMMIT: w_state_next = S_HOLD;
            S_ERROR:  w_state_next = S_HOLD;
            default:  w_state_next = S_HOLD;
        endcase
    end

    // Output logic
    always_comb begin
        o_ready      = (r_state == S_HOLD);
        o_resp_valid = (r_state == S_COMMIT);
        o_resp_error = (r_state == S_ERROR);
    end

    // Counters
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_hold_cnt <= '0;
            r_tmo      <= '0;
            r_dly      <= '0;
            r_bitcnt   <= '0;
        end else begin
            if (r_state == S_HOLD && w_state_next == S_HOLD) begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end else begin
                r_hold_cnt <= '0;
            end

            // The count restarts on each accepted falling edge. It is not cleared
            // between WAIT_HIGH and the next WAIT_EDGE.
            case (r_state)
                S_WAIT_EDGE: r_tmo <= (w_state_next == S_SAMPLE) ? '0 : w_tmo_inc;
                S_SAMPLE,
                S_WAIT_HIGH: r_tmo <= w_tmo_inc;
                default:     r_tmo <= '0;
            endcase

            if (r_state == S_SAMPLE) begin
                r_dly <= r_dly + 1'b1;
            end else begin
                r_dly <= '0;
            end

            if (r_state == S_HOLD || r_state == S_ARM) begin
                r_bitcnt <= '0;
            end else if (w_sample_now) begin
                r_bitcnt <= r_bitcnt + 1'b1;
            end
        end
    end

    // Response shift register. Its stale contents never reach the output
    // unless a complete frame has been received.
    always_ff @(posedge i_clk) begin
        if (w_sample_now) begin
            r_shift <= {r_shift[RESP_BITS-2:0], r_sd};
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_resp_data <= '0;
        end else if (w_commit) begin
            r_resp_data <= r_shift;
        end
    end

    assign o_resp_data = r_resp_data;

endmodule

// File: tb/tb_gc_response_rx.sv
// -----------------------------------------------------------------------------
// tb_gc_response_rx
// Scoreboard bench for gc_response_rx. Each expected resp_valid/resp_error pulse
// (kind, data, cycle) is queued when the stimulus that causes it is driven. A
// monitor on the falling clock edge pops and compares entries as pulses appear.
// READY_HOLD is shortened to keep the run brief. All other timing uses the real
// values: a 1 bit is 60 cycles low then 180 high, and a 0 bit is 180 low then 60 high.
// -----------------------------------------------------------------------------
module tb_gc_response_rx;

    localparam int SAMPLE_DLY = 120;
    localparam int FIRST_TMO  = 600;
    localparam int BIT_TMO    = 300;
    localparam int READY_HOLD = 2000;
    localparam int RESP_BITS  = 64;
    localparam int T_SHORT    = 60;
    localparam int T_LONG     = 180;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        gc_enable;
    logic        gc_data;
    logic        ready;
    logic [63:0] resp_data;
    logic        resp_valid;
    logic        resp_error;

    int          cyc      = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] model_data = '0;

    typedef struct {
        logic        is_err;
        logic [63:0] data;
        int          at;
    } exp_t;
    exp_t sb[$];

    gc_response_rx #(
        .SAMPLE_DLY (SAMPLE_DLY),
        .FIRST_TMO  (FIRST_TMO),
        .BIT_TMO    (BIT_TMO),
        .READY_HOLD (READY_HOLD),
        .RESP_BITS  (RESP_BITS)
    ) dut (
        .i_clk        (clk),
        .i_reset_n    (reset_n),
        .i_gc_enable  (gc_enable),
        .i_gc_data    (gc_data),
        .o_ready      (ready),
        .o_resp_data  (resp_data),
        .o_resp_valid (resp_valid),
        .o_resp_error (resp_error)
    );

    always #8 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge before driving.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_pulse(input logic is_err, input int at);
        exp_t e;
        e.is_err = is_err;
        e.data   = model_data;
        e.at     = at;
        sb.push_back(e);
    endtask

    task automatic send_bit(input logic b, input logic glitch);
        gc_data = 1'b0;
        step(b ? T_SHORT : T_LONG);
        gc_data = 1'b1;
        if (b && glitch) begin
            // A 100 ns low glitch that lands inside the sampling window.
            step(20);
            gc_data = 1'b0;
            step(6);
            gc_data = 1'b1;
            step(T_LONG - 26);
        end else begin
            step(b ? T_LONG : T_SHORT);
        end
    endtask

    // Sends the first nbits of w, MSB first. If commit is set, the resp_valid
    // pulse is queued before the last data bit is sent. A falling edge driven at
    // cycle F reaches the FSM at F+3, and the bit is sampled at F+3+SAMPLE_DLY,
    // which puts the FSM in WAIT_HIGH at F+SAMPLE_DLY+3. Commit follows once the
    // synchronized line is high: at F+low+3 or F+SAMPLE_DLY+4, whichever is later.
    task automatic send_word(input logic [63:0] w, input int nbits, input logic glitch,
                             input logic commit);
        for (int i = 0; i < nbits; i++) begin
            logic b;
            b = w[63-i];
            if (commit && i == RESP_BITS - 1) begin
                int lo;
                int at;
                lo = b ? T_SHORT : T_LONG;
                at = (lo + 3 > SAMPLE_DLY + 4) ? cyc + lo + 3 : cyc + SAMPLE_DLY + 4;
                model_data = w;
                expect_pulse(1'b0, at);
            end
            send_bit(b, glitch);
        end
    endtask

    task automatic wait_armed();
        int n;
        n = 0;
        while (ready && n < READY_HOLD + 20) begin
            step(1);
            n++;
        end
        check_eq("armed", 64'(ready), 64'd0);
    endtask

    task automatic measure_hold(input string tag);
        int n;
        n = 0;
        while (ready && n < READY_HOLD + 20) begin
            step(1);
            n++;
        end
        check_eq(tag, 64'(n), 64'(READY_HOLD));
    endtask

    always @(negedge clk) begin
        if (resp_valid || resp_error) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_pulse", 64'({resp_valid, resp_error}), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_eq(e.is_err ? "error_pulse_kind" : "valid_pulse_kind",
                         64'({resp_valid, resp_error}), e.is_err ? 64'd1 : 64'd2);
                check_eq("resp_data", resp_data, e.data);
                check_eq("pulse_cycle", 64'(cyc), 64'(e.at));
            end
        end
    end

    initial begin
        #(16 * 150000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] w0;
        logic [63:0] w1;
        logic [63:0] w2;
        logic [63:0] w3;
        w0 = 64'h8000_00FF_1234_5678;
        w1 = 64'hFEDC_BA98_7654_3210;
        w2 = 64'h0123_4567_89AB_CDEF;
        w3 = 64'hA5A5_0F0F_C3C3_7E7E;

        reset_n   = 1'b0;
        gc_enable = 1'b0;
        gc_data   = 1'b1;
        step(3);
        check_eq("reset_ready", 64'(ready), 64'd1);
        check_eq("reset_data", resp_data, 64'd0);
        check_eq("reset_valid", 64'(resp_valid), 64'd0);
        check_eq("reset_error", 64'(resp_error), 64'd0);

        // Ready hold length after reset
        reset_n = 1'b1;
        measure_hold("hold_len");

        // Full frame
        gc_enable = 1'b1;
        step(20);
        send_word(w0, 64, 1'b0, 1'b1);
        send_bit(1'b1, 1'b0);
        gc_enable = 1'b0;
        step(2);
        check_eq("ready_after_commit", 64'(ready), 64'd1);

        // No edge after release. The enable register plus the ARM exit add 2 cycles.
        wait_armed();
        gc_enable = 1'b1;
        expect_pulse(1'b1, cyc + FIRST_TMO + 2);
        step(FIRST_TMO + 10);
        check_eq("ready_after_first_tmo", 64'(ready), 64'd1);
        gc_enable = 1'b0;

        // Line stalls after 20 bits. The synchronizer plus the SAMPLE entry add 3 cycles.
        wait_armed();
        gc_enable = 1'b1;
        step(20);
        send_word(w1, 19, 1'b0, 1'b0);
        expect_pulse(1'b1, cyc + BIT_TMO + 3);
        send_bit(w1[44], 1'b0);
        step(BIT_TMO);
        check_eq("ready_after_bit_tmo", 64'(ready), 64'd1);
        gc_enable = 1'b0;

        // Enable drops mid-frame
        wait_armed();
        gc_enable = 1'b1;
        step(20);
        send_word(w2, 10, 1'b0, 1'b0);
        expect_pulse(1'b1, cyc + 2);
        gc_enable = 1'b0;
        step(10);

        // Line activity while the bus is not released, then reset mid-frame
        wait_armed();
        for (int i = 0; i < 8; i++) begin
            send_bit(i[0], 1'b0);
        end
        step(5);
        check_eq("armed_after_toggles", 64'(ready), 64'd0);
        gc_enable = 1'b1;
        step(20);
        send_word(w2, 30, 1'b0, 1'b0);
        gc_data = 1'b0;
        step(30);
        reset_n = 1'b0;
        #1;
        check_eq("midframe_reset_ready", 64'(ready), 64'd1);
        check_eq("midframe_reset_data", resp_data, 64'd0);
        model_data = '0;
        step(2);
        gc_data   = 1'b1;
        gc_enable = 1'b0;
        step(2);
        reset_n = 1'b1;
        measure_hold("hold_len_after_reset");

        // Full frame with a sampling-window glitch on every 1 bit
        gc_enable = 1'b1;
        step(20);
        send_word(w3, 64, 1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        gc_enable = 1'b0;
        step(5);

        check_eq("pending_pulses", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
